// File: rtl/uart_host_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_host_master
//  Purpose  : Bus-side initiator for the UART core's parallel register port.
//             Turns a valid/ready byte stream into UART write strobes, polls
//             RXRDY to pull received bytes into a 2-deep valid/ready output
//             stream, and keeps sticky copies of the UART error flags.
//  Build    : define UART_HOST_MASTER_DROP_ERR_EN to discard received bytes
//             carrying a parity/framing error (counted in RX_DROP_CNT);
//             otherwise every byte is delivered with its RX_ERR tag.
//  Ports    : CLK, RESET_N (async, active-low)
//             TX_VALID/TX_DATA/TX_READY      - byte stream towards the UART
//             RX_VALID/RX_DATA/RX_ERR/RX_READY - byte stream from the UART
//             UART_CSN/WEN/OEN/WDATA         - strobes and data to the UART
//             UART_RDATA/TXRDY/RXRDY/PERR/FERR/OVF - UART read data/status
//             ERR_STATUS/ERR_CLR             - sticky {ovf, ferr, perr}
//             RX_DROP_CNT                    - saturating dropped-byte count
//  Revision : 1.0 - initial release
// ============================================================================
module uart_host_master #(
  parameter int WR_GAP = 2,
  parameter int RD_GAP = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       TX_VALID,
  input  logic [7:0] TX_DATA,
  output logic       TX_READY,
  output logic       RX_VALID,
  output logic [7:0] RX_DATA,
  output logic       RX_ERR,
  input  logic       RX_READY,
  output logic       UART_CSN,
  output logic       UART_WEN,
  output logic       UART_OEN,
  output logic [7:0] UART_WDATA,
  input  logic [7:0] UART_RDATA,
  input  logic       UART_TXRDY,
  input  logic       UART_RXRDY,
  input  logic       UART_PERR,
  input  logic       UART_FERR,
  input  logic       UART_OVF,
  output logic [2:0] ERR_STATUS,
  input  logic       ERR_CLR,
  output logic [7:0] RX_DROP_CNT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_HOLD = 3'd2,
    RD      = 3'd3,
    RD_HOLD = 3'd4
  } state_t;

  localparam logic [3:0] WR_GAP_CNT = 4'(WR_GAP);
  localparam logic [3:0] RD_GAP_CNT = 4'(RD_GAP);

  state_t     state;
  state_t     next_state;
  logic [3:0] gap_cnt;
  logic [3:0] next_gap_cnt;

  logic       rx_take;
  logic       tx_accept;
  logic       wr_cycle;
  logic       rd_cycle;
  logic       cap_err;
  logic       push;
  logic       pop;

  logic [1:0] rx_count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [7:0] rx_mem [2];
  logic [7:0] wdata;
  logic [2:0] err_status;

  // --------------------------------------------------------------------------
  // Arbitration: a pending received byte beats a pending transmit byte.
  // TX_READY is also gated by RESET_N so it reads 0 while reset is held even
  // though the state register already sits in IDLE.
  // --------------------------------------------------------------------------
  assign rx_take   = (state == IDLE) & UART_RXRDY & (rx_count != 2'd2);
  assign TX_READY  = RESET_N & (state == IDLE) & UART_TXRDY & ~rx_take;
  assign tx_accept = TX_VALID & TX_READY;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      gap_cnt <= 4'd0;
    end else begin
      state   <= next_state;
      gap_cnt <= next_gap_cnt;
    end
  end

  // Hold states last exactly GAP cycles, so consecutive accesses are spaced
  // GAP+2 cycles apart (strobe, GAP hold cycles, one IDLE decision cycle).
  always_comb begin
    next_state   = state;
    next_gap_cnt = gap_cnt;
    case (state)
      IDLE: begin
        if (rx_take) begin
          next_state = RD;
        end else if (tx_accept) begin
          next_state = WR;
        end
      end
      WR: begin
        next_state   = WR_HOLD;
        next_gap_cnt = WR_GAP_CNT;
      end
      WR_HOLD: begin
        next_gap_cnt = gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1) begin
          next_state = IDLE;
        end
      end
      RD: begin
        next_state   = RD_HOLD;
        next_gap_cnt = RD_GAP_CNT;
      end
      RD_HOLD: begin
        next_gap_cnt = gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state   = IDLE;
        next_gap_cnt = 4'd0;
      end
    endcase
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset releases them immediately.
  assign wr_cycle   = (state == WR);
  assign rd_cycle   = (state == RD);
  assign UART_CSN   = ~(wr_cycle | rd_cycle);
  assign UART_WEN   = ~wr_cycle;
  assign UART_OEN   = ~rd_cycle;
  assign UART_WDATA = wdata;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wdata <= 8'h00;
    end else if (tx_accept) begin
      wdata <= TX_DATA;
    end
  end

  // --------------------------------------------------------------------------
  // Receive capture into the 2-entry buffer. Reads are only started with a
  // free entry, and the count cannot grow before the push, so a push never
  // meets a full buffer.
  // --------------------------------------------------------------------------
  assign cap_err = UART_PERR | UART_FERR;

`ifdef UART_HOST_MASTER_DROP_ERR_EN
  assign push = rd_cycle & ~cap_err;
`else
  assign push = rd_cycle;
`endif
  assign pop  = RX_VALID & RX_READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rx_count  <= 2'd0;
      rx_mem[0] <= 8'h00;
      rx_mem[1] <= 8'h00;
    end else begin
      if (push) begin
        rx_mem[wr_ptr] <= UART_RDATA;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   rx_count <= rx_count + 2'd1;
        2'b01:   rx_count <= rx_count - 2'd1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  assign RX_VALID = (rx_count != 2'd0);
  assign RX_DATA  = rx_mem[rd_ptr];

`ifdef UART_HOST_MASTER_DROP_ERR_EN
  // Errored bytes never enter the buffer, so the tag is always clear.
  logic [7:0] drop_cnt;

  assign RX_ERR = 1'b0;

  // A drop in the same cycle as ERR_CLR still increments.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      drop_cnt <= 8'h00;
    end else if (rd_cycle & cap_err) begin
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'h01;
      end
    end else if (ERR_CLR) begin
      drop_cnt <= 8'h00;
    end
  end

  assign RX_DROP_CNT = drop_cnt;
`else
  logic rx_err_mem [2];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_err_mem[0] <= 1'b0;
      rx_err_mem[1] <= 1'b0;
    end else if (push) begin
      rx_err_mem[wr_ptr] <= cap_err;
    end
  end

  assign RX_ERR      = rx_err_mem[rd_ptr];
  assign RX_DROP_CNT = 8'h00;
`endif

  // --------------------------------------------------------------------------
  // Sticky error flags; a set in the same cycle as ERR_CLR survives.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_status <= 3'b000;
    end else if (rd_cycle) begin
      err_status <= (ERR_CLR ? 3'b000 : err_status) | {UART_OVF, UART_FERR, UART_PERR};
    end else if (ERR_CLR) begin
      err_status <= 3'b000;
    end
  end

  assign ERR_STATUS = err_status;

endmodule
`default_nettype wire

// File: tb/tb_uart_host_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_host_master
//  Purpose  : Self-checking bench for uart_host_master. A behavioural UART
//             peer feeds bytes and ready flags; a cycle-level reference
//             model built from the access-spacing, latency and buffering
//             rules predicts strobes, stream outputs and status.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_host_master;

  localparam int WR_GAP = 2;
  localparam int RD_GAP = 2;
`ifdef UART_HOST_MASTER_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       TX_VALID;
  logic [7:0] TX_DATA;
  logic       TX_READY;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic       RX_ERR;
  logic       RX_READY;
  logic       UART_CSN;
  logic       UART_WEN;
  logic       UART_OEN;
  logic [7:0] UART_WDATA;
  logic [7:0] UART_RDATA;
  logic       UART_TXRDY;
  logic       UART_RXRDY;
  logic       UART_PERR;
  logic       UART_FERR;
  logic       UART_OVF;
  logic [2:0] ERR_STATUS;
  logic       ERR_CLR;
  logic [7:0] RX_DROP_CNT;

  always #5 CLK = ~CLK;

  uart_host_master #(.WR_GAP(WR_GAP), .RD_GAP(RD_GAP)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .TX_VALID   (TX_VALID),
    .TX_DATA    (TX_DATA),
    .TX_READY   (TX_READY),
    .RX_VALID   (RX_VALID),
    .RX_DATA    (RX_DATA),
    .RX_ERR     (RX_ERR),
    .RX_READY   (RX_READY),
    .UART_CSN   (UART_CSN),
    .UART_WEN   (UART_WEN),
    .UART_OEN   (UART_OEN),
    .UART_WDATA (UART_WDATA),
    .UART_RDATA (UART_RDATA),
    .UART_TXRDY (UART_TXRDY),
    .UART_RXRDY (UART_RXRDY),
    .UART_PERR  (UART_PERR),
    .UART_FERR  (UART_FERR),
    .UART_OVF   (UART_OVF),
    .ERR_STATUS (ERR_STATUS),
    .ERR_CLR    (ERR_CLR),
    .RX_DROP_CNT(RX_DROP_CNT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / peer state ----------------
  int          cyc;
  int          next_idle;     // first cycle the master may decide a new access
  bit          pend_rd;       // a read strobe is due this cycle
  bit          pend_wr;       // a write strobe is due this cycle
  logic [7:0]  tx_src [$];    // bytes still to be offered on TX
  logic [10:0] rx_src [$];    // {ovf, ferr, perr, data} the UART will deliver
  logic [8:0]  rx_exp [$];    // {err, data} bytes held in the output buffer
  int          rx_wait;
  logic [2:0]  m_status;
  int          m_drop;
  logic [7:0]  m_wdata;
  int          p_txv, p_txrdy, p_rxready, p_clr;
  bit          clr_on_read;

  task automatic drive_inputs();
    if (tx_src.size() == 0) TX_VALID = 1'b0;
    else if (!TX_VALID && ($urandom_range(0, 99) < p_txv)) TX_VALID = 1'b1;
    TX_DATA    = (tx_src.size() > 0) ? tx_src[0] : 8'($urandom);
    UART_TXRDY = ($urandom_range(0, 99) < p_txrdy);
    UART_RXRDY = (rx_src.size() > 0) && (rx_wait == 0);
    if (UART_RXRDY) {UART_OVF, UART_FERR, UART_PERR, UART_RDATA} = rx_src[0];
    else begin
      UART_RDATA = 8'($urandom);
      {UART_OVF, UART_FERR, UART_PERR} = 3'($urandom);
    end
    RX_READY = ($urandom_range(0, 99) < p_rxready);
    ERR_CLR  = clr_on_read ? pend_rd : ($urandom_range(0, 99) < p_clr);
  endtask

  // One clock cycle: check at the falling edge, advance the model, then
  // drive new inputs just after the rising edge.
  task automatic step();
    bit          idle, rd_take, exp_trdy, tx_fire, pop, err, consumed;
    logic [10:0] f;
    f = '0;
    @(negedge CLK);
    idle     = (cyc >= next_idle);
    rd_take  = idle && UART_RXRDY && (rx_exp.size() < 2);
    exp_trdy = idle && UART_TXRDY && !rd_take;
    tx_fire  = exp_trdy && TX_VALID;
    pop      = (rx_exp.size() > 0) && RX_READY;

    check("tx_ready", TX_READY, exp_trdy);
    check("strobes", {UART_CSN, UART_WEN, UART_OEN},
          pend_rd ? 3'b010 : (pend_wr ? 3'b001 : 3'b111));
    check("rx_valid", RX_VALID, rx_exp.size() > 0);
    check("wdata", UART_WDATA, m_wdata);
    check("err_status", ERR_STATUS, m_status);
    check("drop_cnt", RX_DROP_CNT, m_drop);

    if (pop) begin
      check("rx_data", RX_DATA, rx_exp[0][7:0]);
      check("rx_err", RX_ERR, rx_exp[0][8]);
      void'(rx_exp.pop_front());
    end

    if (pend_rd) f = rx_src[0];
    err = f[9] | f[8];
    if (pend_rd && DROP && err) begin
      if (m_drop < 255) m_drop++;
    end else if (ERR_CLR) begin
      m_drop = 0;
    end
    if (pend_rd && !(DROP && err)) rx_exp.push_back({err & ~DROP, f[7:0]});
    m_status = (ERR_CLR ? 3'b000 : m_status) | (pend_rd ? f[10:8] : 3'b000);

    if (tx_fire) m_wdata = TX_DATA;
    consumed = pend_rd;
    pend_rd  = rd_take;
    pend_wr  = tx_fire;
    if (rd_take) next_idle = cyc + RD_GAP + 2;
    if (tx_fire) next_idle = cyc + WR_GAP + 2;
    cyc++;

    @(posedge CLK);
    #1;
    if (tx_fire) begin
      void'(tx_src.pop_front());
      TX_VALID = 1'b0;
    end
    if (consumed) begin
      void'(rx_src.pop_front());
      rx_wait = $urandom_range(0, 3);
    end else if (rx_wait > 0) begin
      rx_wait--;
    end
    drive_inputs();
  endtask

  task automatic apply_reset();
    RESET_N    = 1'b0;
    TX_VALID   = 1'b1;
    UART_TXRDY = 1'b1;
    UART_RXRDY = 1'b1;
    RX_READY   = 1'b1;
    ERR_CLR    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_csn", UART_CSN, 1'b1);
    check("rst_wen", UART_WEN, 1'b1);
    check("rst_oen", UART_OEN, 1'b1);
    check("rst_wdata", UART_WDATA, 8'h00);
    check("rst_tx_ready", TX_READY, 1'b0);
    check("rst_rx_valid", RX_VALID, 1'b0);
    check("rst_rx_data", RX_DATA, 8'h00);
    check("rst_rx_err", RX_ERR, 1'b0);
    check("rst_err_status", ERR_STATUS, 3'b000);
    check("rst_drop_cnt", RX_DROP_CNT, 8'h00);
    rx_exp.delete();
    pend_rd   = 1'b0;
    pend_wr   = 1'b0;
    m_status  = 3'b000;
    m_drop    = 0;
    m_wdata   = 8'h00;
    cyc       = 0;
    next_idle = 0;
    rx_wait   = 0;
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    drive_inputs();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((tx_src.size() + rx_src.size() + rx_exp.size()) != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check("drain", tx_src.size() + rx_src.size() + rx_exp.size(), 0);
    repeat (8) step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET_N = 1'b0; TX_VALID = 1'b0; TX_DATA = 8'h00; RX_READY = 1'b0;
    UART_RDATA = 8'h00; UART_TXRDY = 1'b0; UART_RXRDY = 1'b0;
    UART_PERR = 1'b0; UART_FERR = 1'b0; UART_OVF = 1'b0; ERR_CLR = 1'b0;
    p_txv = 100; p_txrdy = 100; p_rxready = 100; p_clr = 0; clr_on_read = 1'b0;

    apply_reset();

    // Back-to-back transmit bytes.
    tx_src.push_back(8'hA5);
    tx_src.push_back(8'h3C);
    drive_inputs();
    drain(100);
    check("last_wdata", UART_WDATA, 8'h3C);

    // Single clean receive byte.
    rx_src.push_back({3'b000, 8'h5A});
    drive_inputs();
    drain(100);

    // TX and RX request in the same cycle: read goes first.
    tx_src.push_back(8'h77);
    rx_src.push_back({3'b000, 8'h11});
    rx_wait = 0;
    drive_inputs();
    drain(100);

    // Buffer fills with downstream stalled; third byte carries overflow and
    // is read in the same cycle as ERR_CLR.
    p_rxready = 0;
    rx_src.push_back({3'b000, 8'h21});
    rx_src.push_back({3'b000, 8'h22});
    rx_src.push_back({3'b100, 8'h23});
    drive_inputs();
    repeat (30) step();
    clr_on_read = 1'b1;
    p_rxready   = 100;
    drain(200);
    clr_on_read = 1'b0;
    check("ovf_sticky", ERR_STATUS, 3'b100);

    // Parity-error byte.
    rx_src.push_back({3'b001, 8'h81});
    drive_inputs();
    drain(100);
    check("perr_sticky", ERR_STATUS[0], 1'b1);
    check("drop_one", RX_DROP_CNT, DROP ? 8'd1 : 8'd0);

    // 300 parity-error bytes: counter saturates when dropping.
    p_rxready = 70;
    for (int i = 0; i < 300; i++) rx_src.push_back({3'b001, 8'($urandom)});
    drive_inputs();
    drain(6000);
    check("drop_sat", RX_DROP_CNT, DROP ? 8'd255 : 8'd0);

    // Random mixed traffic.
    p_txv = 70; p_txrdy = 70; p_rxready = 60; p_clr = 3;
    for (int i = 0; i < 200; i++) begin
      tx_src.push_back(8'($urandom));
      rx_src.push_back({($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000, 8'($urandom)});
    end
    drive_inputs();
    drain(20000);

    // Asynchronous reset in the middle of a write strobe.
    p_clr = 0; p_txv = 100; p_txrdy = 100; p_rxready = 100;
    tx_src.push_back(8'hC3);
    drive_inputs();
    n = 0;
    while (!pend_wr && n < 50) begin
      step();
      n++;
    end
    check("reach_wr", pend_wr, 1'b1);
    check("wen_in_wr", {UART_CSN, UART_WEN}, 2'b00);
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_csn", UART_CSN, 1'b1);
    check("async_wen", UART_WEN, 1'b1);
    apply_reset();
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
